// File: rtl/div_nm_signed_seq.sv
// Sequential N/M signed restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_CHECK_EN to detect B == 0 and short-circuit the result.
module div_nm_signed_seq #(
    parameter int N = 8,
    parameter int M = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Quot,
    output logic [M-1:0] Rem,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [M-1:0]   b_q, b_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic [M-1:0]   bmag_q, bmag_d;
    logic [N-1:0]   qsr_q, qsr_d;
    logic [M-1:0]   r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [M-1:0]   rem_q, rem_d;
    logic           ovf_q, ovf_d;
    logic           ov_q, ov_d;
`ifdef DIV_ZERO_CHECK_EN
    logic           dbz_q, dbz_d;
`endif

    logic [M:0]     rsh;
    logic [M-1:0]   diff;
    logic           ge;

    // Partial remainder stays below |B| <= 2^(M-1), so M bits hold it;
    // only the shifted trial value needs the extra top bit.
    assign rsh  = {r_q, qsr_q[N-1]};
    assign ge   = rsh >= {1'b0, bmag_q};
    assign diff = rsh[M-1:0] - bmag_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bmag_d  = bmag_q;
        qsr_d   = qsr_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        ov_d    = ov_q;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    qneg_d  = A[N-1] ^ B[M-1];
                    rneg_d  = A[N-1];
`ifdef DIV_ZERO_CHECK_EN
                    dbz_d   = 1'b0;
`endif
                    state_d = PREP;
                end
            end
            PREP: begin
                qsr_d   = a_q[N-1] ? N'(-a_q) : a_q;
                bmag_d  = b_q[M-1] ? M'(-b_q) : b_q;
                r_d     = '0;
                cnt_d   = CW'(N - 1);
                state_d = CALC;
`ifdef DIV_ZERO_CHECK_EN
                // Zero divisor bypasses the iterations; FIX emits the fixed result.
                if (b_q == '0) begin
                    dbz_d   = 1'b1;
                    state_d = FIX;
                end
`endif
            end
            CALC: begin
                qsr_d = {qsr_q[N-2:0], ge};
                r_d   = ge ? diff : rsh[M-1:0];
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                quot_d  = qneg_q ? N'(-qsr_q) : qsr_q;
                rem_d   = rneg_q ? M'(-r_q) : r_q;
                ovf_d   = (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1);
`ifdef DIV_ZERO_CHECK_EN
                if (dbz_q) begin
                    quot_d = '1;
                    rem_d  = '0;
                    ovf_d  = 1'b0;
                end
`endif
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bmag_q  <= '0;
            qsr_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            ov_q    <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bmag_q  <= bmag_d;
            qsr_q   <= qsr_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            ov_q    <= ov_d;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign Quot      = quot_q;
    assign Rem       = rem_q;
    assign overflow  = ovf_q;
`ifdef DIV_ZERO_CHECK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_nm_signed_seq.sv
// Directed and random checks for div_nm_signed_seq (N=8, M=5).
// Expected values are hand-computed or from integer division in the bench.
module tb_div_nm_signed_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = '0;
    logic [4:0] B = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] Quot;
    logic [4:0] Rem;
    logic       div_by_zero;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int takes  = 0;

    always #5 clk = ~clk;

    div_nm_signed_seq #(.N(8), .M(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Quot        (Quot),
        .Rem         (Rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always @(posedge clk)
        if (!rst && out_valid && out_ready) hs_cnt++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int sq(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sr(input logic [4:0] v);
        return int'($signed(v));
    endfunction

    // Present operands, wait for acceptance, return cycles until out_valid.
    task automatic run(input logic [7:0] a, input logic [4:0] b, output int lat);
        int w;
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take(input int stall);
        for (int i = 0; i < stall; i++) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        takes++;
    endtask

    task automatic directed(input string tag, input int a, input int b,
                            input int eq, input int er, input int eo);
        int lat;
        run(8'(a), 5'(b), lat);
        check({tag, "_lat"}, lat, 10);
        check({tag, "_q"}, sq(Quot), eq);
        check({tag, "_r"}, sr(Rem), er);
        check({tag, "_ovf"}, int'(overflow), eo);
        check({tag, "_dbz"}, int'(div_by_zero), 0);
        take(0);
        check({tag, "_ovclr"}, int'(out_valid), 0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [7:0] ra;
        logic [4:0] rb;
        int ai, bi, qi, ri;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quot", int'(Quot), 0);
        check("rst_rem", int'(Rem), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        check("rst_ovf", int'(overflow), 0);

        directed("p100_p7", 100, 7, 14, 2, 0);
        directed("m100_p7", -100, 7, -14, -2, 0);
        directed("p100_m7", 100, -7, -14, 2, 0);

        run(8'h80, 5'h1F, lat);
        check("ovf_lat", lat, 10);
        check("ovf_q", sq(Quot), -128);
        check("ovf_r", sr(Rem), 0);
        check("ovf_flag", int'(overflow), 1);
        take(0);
        run(8'h80, 5'h01, lat);
        check("m128_p1_q", sq(Quot), -128);
        check("m128_p1_r", sr(Rem), 0);
        check("m128_p1_ovf", int'(overflow), 0);
        take(0);

        run(8'd37, 5'd0, lat);
`ifdef DIV_ZERO_CHECK_EN
        check("dz_lat", lat, 2);
        check("dz_q", int'(Quot), 255);
        check("dz_r", int'(Rem), 0);
        check("dz_flag", int'(div_by_zero), 1);
        check("dz_ovf", int'(overflow), 0);
`else
        check("dz_lat", lat, 10);
        check("dz_flag", int'(div_by_zero), 0);
`endif
        take(0);

        // Backpressure with a competing request that must be ignored.
        run(8'(-50), 5'd6, lat);
        check("bp_lat", lat, 10);
        @(negedge clk);
        A = 8'd1;
        B = 5'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_q", sq(Quot), -8);
            check("bp_r", sr(Rem), -2);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take(0);
        check("bp_in_ready_after", int'(in_ready), 1);
        check("bp_out_valid_after", int'(out_valid), 0);

        // Abort an operation with reset partway through.
        @(negedge clk);
        A = 8'd90;
        B = 5'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_quot", int'(Quot), 0);
        check("abort_rem", int'(Rem), 0);
        check("abort_ovf", int'(overflow), 0);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("abort_no_result", seen, 0);
        directed("p90_p9", 90, 9, 10, 0, 0);

        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 5'($urandom_range(1, 31));
            ai = sq(ra);
            bi = sr(rb);
            qi = ai / bi;
            ri = ai - qi * bi;
            run(ra, rb, lat);
            check("rnd_q", sq(Quot), sq(8'(qi)));
            check("rnd_r", sr(Rem), ri);
            take(int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("handshake_count", hs_cnt, takes);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
